// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: WIDTH-bit pipelined carry-lookahead adder/subtractor.
// Each pipeline stage evaluates GRP_PER_STAGE 4-bit lookahead groups, with the
// carry rippling between groups. A valid/ready handshake stalls the whole pipe.
// Optional feature macro: CLA_PIPE_FLAGS_EN enables the ovf/zero flag registers.
// With the macro undefined, ovf and zero are tied to 0.
module cla_pipe_addsub #(
  parameter int WIDTH         = 32,
  parameter int GRP_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW      = 4 * GRP_PER_STAGE;
  localparam int NSTAGES = WIDTH / SW;

  // 4-bit carry-lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Stage k reads index k of these; index k+1 is stage k's registered output.
  logic             st_v   [NSTAGES+1];
  logic             st_c   [NSTAGES+1];
  logic [WIDTH-1:0] st_sum [NSTAGES+1];
  logic [WIDTH-1:0] st_a   [NSTAGES];
  logic [WIDTH-1:0] st_b   [NSTAGES];
  logic             adv;

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_d, ovf_q, zero_d, zero_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  // Effective operands are formed at acceptance; stage 0 sees the raw beat.
  assign st_v[0]   = in_valid;
  assign st_a[0]   = a;
  assign st_b[0]   = sub ? ~b : b;
  assign st_c[0]   = sub ? 1'b1 : cin;
  assign st_sum[0] = '0;

  assign adv       = !st_v[NSTAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = st_v[NSTAGES];
  assign sum       = st_sum[NSTAGES];
  assign cout      = st_c[NSTAGES];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic             v_d, v_q, c_d, c_q, c_nx;
    logic [WIDTH-1:0] sum_d, sum_q, sum_nx;

    // Evaluate this stage's slice, rippling the carry from group to group
    always_comb begin
      logic [4:0] r;
      logic       cy;
      r      = '0;
      sum_nx = st_sum[k];
      cy     = st_c[k];
      for (int unsigned j = 0; j < GRP_PER_STAGE; j++) begin
        r = cla4(st_a[k][k*SW + 4*j +: 4], st_b[k][k*SW + 4*j +: 4], cy);
        sum_nx[k*SW + 4*j +: 4] = r[3:0];
        cy = r[4];
      end
      c_nx = cy;
    end

    // Load from the stage below only when the pipe advances
    always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      sum_d = sum_q;
      if (adv) begin
        v_d   = st_v[k];
        c_d   = c_nx;
        sum_d = sum_nx;
      end
    end

    // Stage state register with synchronous clear
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        v_q   <= v_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    assign st_v[k+1]   = v_q;
    assign st_c[k+1]   = c_q;
    assign st_sum[k+1] = sum_q;

    if (k < NSTAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_d, a_q, b_d, b_q;

      // Carry the operands forward so upper slices meet their stage in step
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = st_a[k];
          b_d = st_b[k];
        end
      end

      // Operand skew register with synchronous clear
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign st_a[k+1] = a_q;
      assign st_b[k+1] = b_q;
    end

    if (k == NSTAGES - 1) begin : g_last
`ifdef CLA_PIPE_FLAGS_EN
      // Flags come from the fully assembled sum so they land with it
      always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (adv) begin
          ovf_d  = (st_a[k][WIDTH-1] == st_b[k][WIDTH-1]) &&
                   (sum_nx[WIDTH-1] != st_a[k][WIDTH-1]);
          zero_d = (sum_nx == '0);
        end
      end

      // Flag registers with synchronous clear
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
`endif
    end
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. It generalises the two-group 8-bit CLA into a WIDTH-bit unit built from 4-bit lookahead groups, with pipeline registers between slices of groups and a valid/ready handshake with backpressure. It also supports an add/subtract mode and status flags. It sits between the ALU operand muxes and the result bus wherever a wide add does not close timing in one cycle.

## Interface
- WIDTH, 32, operand/result width; multiple of 4, minimum 8.
- GRP_PER_STAGE, 2, number of 4-bit CLA groups evaluated per pipeline stage. (4*GRP_PER_STAGE) must divide WIDTH.
- NSTAGES is derived, not settable: NSTAGES = WIDTH/(4*GRP_PER_STAGE).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in, used only when sub=0.
- sub  in  1  1 = A-B (B inverted, carry in forced 1); 0 = A+B+cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB. For subtraction, 1 = no borrow (A>=B unsigned).
- ovf  out  1  signed two's-complement overflow (see Configuration).
- zero  out  1  sum == 0 (see Configuration).

## Operation
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin. These are formed at acceptance.
- Stage k (0..NSTAGES-1) takes the operand bits of slice k (bits [4*GRP_PER_STAGE*(k+1)-1 : 4*GRP_PER_STAGE*k]) and the carry registered by stage k-1. Stage 0 uses c0.
  - Within a stage, groups use 4-bit generate/propagate with ripple between groups, as in the existing 8-bit CLA.
  - The stage registers its sum bits, its carry out, and the slice's MSB operand bits when it is the top slice.
- Operand skew: slices above k are delayed in per-stage registers until their stage. Completed lower sum bits are carried forward with the beat.
- Each stage holds a valid bit. The global advance enable is adv = !out_valid || out_ready.
  - When adv=1, every stage register loads from the stage below it. Stage 0 loads the input beat when in_valid, otherwise a bubble (valid=0).
  - When adv=0, all stage registers hold.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Bubbles propagate; there is no compaction of bubbles under stall.
- out_* are the final-stage registers and hold stable while out_valid && !out_ready.
- Arithmetic: {cout,sum} = A + bb + c0, computed in WIDTH+1 bits. ovf = (A[W-1] == bb[W-1]) && (sum[W-1] != A[W-1]).
- sum, cout, ovf and zero for a beat all appear together.

## Timing
- Latency: a beat accepted at edge t has out_valid=1 after edge t+NSTAGES. This assumes no stall; each stall cycle adds one. With the defaults, latency is 4.
- Throughput: one beat per cycle while out_ready=1.
- Reset (rst_n=0 at an edge): all stage valid bits clear, and all data registers clear to 0.
  - After that edge: out_valid=0, sum=0, cout=0, ovf=0, zero=0, and in_ready=1.
  - A beat presented in the reset cycle is not accepted.
- Reset mid-operation: all in-flight beats are discarded. No partial result is emitted.
- Simultaneous accept and drain in the same cycle is legal and sustains full throughput.
- out_valid && !out_ready: in_ready=0 in that same cycle, and the input is not sampled.
- An output register only changes at an edge where adv=1.

## Configuration
- CLA_PIPE_FLAGS_EN defined:
  - ovf and zero are computed in the final stage and registered with sum.
  - zero is reduced from the full assembled sum.
- CLA_PIPE_FLAGS_EN undefined:
  - ovf and zero are tied to 0.
  - Their registers and logic are not instantiated.
  - sum, cout and the handshake are unaffected.

## Test plan
- Reset/idle, defaults: hold rst_n=0 for 2 cycles, then release. Required: out_valid=0, sum=0, in_ready=1. A beat presented during reset never appears at the output.
- Basic add:
  - a=0x0000_FFFF, b=0x0000_0001, cin=0, sub=0, single beat. Result after 4 cycles: sum=0x0001_0000, cout=0, ovf=0, zero=0.
  - Carry chain through all stages: a=0xFFFF_FFFF, b=0, cin=1. Result: sum=0, cout=1, zero=1.
- Subtract:
  - a=5, b=7, sub=1 → sum=0xFFFF_FFFE, cout=0.
  - a=0x8000_0000, b=1, sub=1 → sum=0x7FFF_FFFF, ovf=1, cout=1.
- Streaming with backpressure:
  - Drive 20 back-to-back beats with random operands, holding out_ready=0 for cycles 6–9.
  - Required: every result matches the model, in order. Outputs are stable during the stall, and in_ready=0 exactly while out_valid && !out_ready.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight. Required: none of them appears, and the first post-reset beat has latency 4.
- Parameter sweep: repeat the random streaming test for these configurations. Required: latency equals NSTAGES and all results are correct.
  - WIDTH=8, GRP_PER_STAGE=1 (latency 2)
  - WIDTH=16, GRP_PER_STAGE=4 (latency 1)
  - WIDTH=64, GRP_PER_STAGE=2 (latency 8)

  Run each configuration once with CLA_PIPE_FLAGS_EN defined and once without it. Without the macro, ovf and zero must be constant 0.
